// File: rtl/aes_ctr_stream_engine.sv
// AES-CTR streaming engine: issues LANES counter blocks per accepted beat to
// a fixed-latency AES core, XORs the aligned plaintext with the returning
// keystream and buffers ciphertext in a credit-managed output FIFO.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               one-cycle job start (sampled in IDLE only)
//   iv, ctr_init        nonce (block bits [127:64]) and lane-0 start counter
//   num_beats           beats in the job (0 = immediate done)
//   in_valid/in_ready   plaintext beat handshake, in_data = LANES x 128 bits
//   aes_valid_out       counter blocks on aes_state_out are valid
//   aes_ks_in           keystream, AES_LATENCY cycles after issue
//   out_valid/out_ready ciphertext beat handshake, out_data
//   busy                job in progress
//   done                one-cycle pulse when the last beat leaves the FIFO
module aes_ctr_stream_engine #(
    parameter int LANES       = 4,
    parameter int AES_LATENCY = 21,
    parameter int FIFO_DEPTH  = 32,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [63:0]            iv,
    input  logic [63:0]            ctr_init,
    input  logic [CNT_W-1:0]       num_beats,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*128-1:0]   in_data,
    output logic                   aes_valid_out,
    output logic [LANES*128-1:0]   aes_state_out,
    input  logic [LANES*128-1:0]   aes_ks_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*128-1:0]   out_data,
    output logic                   busy,
    output logic                   done
);

    localparam int BW = LANES * 128;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;
    localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic [63:0]      r_iv;
    logic [63:0]      r_ctr;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_retired;
    logic             r_zero_done;

    logic             r_aes_valid;
    logic [BW-1:0]    r_aes_state;

    logic [BW-1:0]        r_dl_data [0:AES_LATENCY];
    logic [AES_LATENCY:0] r_dl_vld;

    logic [BW-1:0] r_mem [0:FIFO_DEPTH-1];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [AW:0]   r_inflight;

    logic [AW:0]   w_count;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_credit;
    logic          w_in_ready;
    logic          w_in_acc;
    logic          w_out_acc;
    logic          w_last_in;
    logic          w_last_out;
    logic          w_fifo_wr;
    logic [BW-1:0] w_fifo_din;
    logic [BW-1:0] w_blocks;

    assign w_count  = r_wptr - r_rptr;
    assign w_empty  = (w_count == '0);
    assign w_full   = (w_count == DEPTH_P);

    // Every issued beat reserves a FIFO slot, so the FIFO cannot overflow
    // even though the AES core cannot be stalled.
    assign w_credit = CW'(r_inflight) + CW'(w_count);

    assign w_in_ready = (r_state == S_RUN)
                     && (r_issued < r_num)
                     && (w_credit < CW'(FIFO_DEPTH));

    assign w_in_acc   = in_valid && w_in_ready;
    assign w_out_acc  = !w_empty && out_ready;
    assign w_last_in  = w_in_acc && (r_issued == r_num - CNT_W'(1));
    assign w_last_out = (r_state == S_DRAIN) && w_out_acc
                     && (r_retired == r_num - CNT_W'(1));

    assign w_fifo_wr  = r_dl_vld[AES_LATENCY];
    assign w_fifo_din = r_dl_data[AES_LATENCY] ^ aes_ks_in;

    // Lane counters wrap modulo 2^64; the nonce half never changes.
    always_comb begin
        w_blocks = '0;
        for (int i = 0; i < LANES; i++) begin
            w_blocks[128*i +: 128] = {r_iv, r_ctr + 64'(i)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_iv        <= '0;
            r_ctr       <= '0;
            r_num       <= '0;
            r_issued    <= '0;
            r_retired   <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_iv      <= iv;
                        r_ctr     <= ctr_init;
                        r_num     <= num_beats;
                        r_issued  <= '0;
                        r_retired <= '0;
                        if (num_beats == '0) begin
                            r_zero_done <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_last_in) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_out) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_in_acc) begin
                r_ctr    <= r_ctr + 64'(LANES);
                r_issued <= r_issued + CNT_W'(1);
            end
            if (w_out_acc) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aes_valid <= 1'b0;
            r_aes_state <= '0;
        end else begin
            r_aes_valid <= w_in_acc;
            if (w_in_acc) begin
                r_aes_state <= w_blocks;
            end
        end
    end

    // Plaintext travels AES_LATENCY+1 stages so its last stage lines up
    // with the keystream for the same beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dl_vld <= '0;
            for (int k = 0; k <= AES_LATENCY; k++) begin
                r_dl_data[k] <= '0;
            end
        end else begin
            r_dl_vld     <= {r_dl_vld[AES_LATENCY-1:0], w_in_acc};
            r_dl_data[0] <= in_data;
            for (int k = 1; k <= AES_LATENCY; k++) begin
                r_dl_data[k] <= r_dl_data[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            if (w_in_acc && !w_fifo_wr) begin
                r_inflight <= r_inflight + (AW+1)'(1);
            end else if (!w_in_acc && w_fifo_wr) begin
                r_inflight <= r_inflight - (AW+1)'(1);
            end
            if (w_fifo_wr) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_out_acc) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wptr[AW-1:0]] <= w_fifo_din;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset) w_fifo_wr |-> !w_full
    );

    assign in_ready      = w_in_ready;
    assign aes_valid_out = r_aes_valid;
    assign aes_state_out = r_aes_state;
    assign out_valid     = !w_empty;
    assign out_data      = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign busy          = (r_state != S_IDLE);
    assign done          = r_zero_done || w_last_out;

endmodule

// File: doc/aes_ctr_stream_engine.md
Name: aes_ctr_stream_engine

Overview:
- Parametrised AES-CTR streaming engine for the AFU data path, generalising the single-block IV+counter generator to LANES parallel 128-bit lanes per beat.
- Issues counter blocks to an external fixed-latency pipelined AES core, aligns incoming plaintext with the returning keystream, XORs the two, and buffers the ciphertext in a credit-managed output FIFO with valid/ready backpressure toward the CCI write path.
- Job control (start, beat count, done) is driven by the CSR layer.

Parameters:
- LANES, 4, number of 128-bit AES blocks per beat; beat width is LANES*128, so the default is one 512-bit cache line.
- AES_LATENCY, 21, fixed cycles from aes_state_out to the matching aes_ks_in; the core cannot be stalled.
- FIFO_DEPTH, 32, output FIFO entries; power of two, >= 2.
- CNT_W, 32, width of the beat-count input and internal beat counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle job start; sampled only in IDLE
- iv  in  64  nonce; forms bits [127:64] of every counter block
- ctr_init  in  64  initial counter for lane 0 of beat 0
- num_beats  in  CNT_W  beats in the job
- in_valid  in  1  plaintext beat valid
- in_ready  out  1  plaintext beat accepted when in_valid && in_ready
- in_data  in  LANES*128  plaintext; lane i occupies bits [128*i +: 128]
- aes_valid_out  out  1  counter blocks issued this cycle
- aes_state_out  out  LANES*128  counter blocks to the AES core
- aes_ks_in  in  LANES*128  keystream from the core, AES_LATENCY cycles after issue
- out_valid  out  1  ciphertext beat available
- out_ready  in  1  consumer accepts the beat
- out_data  out  LANES*128  ciphertext
- busy  out  1  job in progress (state != IDLE)
- done  out  1  one-cycle pulse when the last beat is accepted at the output

Behaviour:
- Reset (asynchronous) values: state=IDLE; in_ready, aes_valid_out, out_valid, busy, done all 0; aes_state_out, out_data, FIFO pointers, credit counter, beat counters and the delay line are 0.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start, latching iv, ctr_init and num_beats. If num_beats==0, go straight to IDLE instead and pulse done the next cycle.
  - RUN -> DRAIN in the cycle the num_beats-th input beat is accepted.
  - DRAIN -> IDLE when the num_beats-th output beat is accepted; done pulses in that same cycle.
  - start is ignored in RUN and DRAIN.
- in_ready = (state==RUN) && issued<num_beats && (inflight+fifo_count) < FIFO_DEPTH. It is derived from registers only and has no combinational path from out_ready.
- On an accepted input beat (cycle T):
  - aes_valid_out=1 and lane i gets aes_state_out = {iv, ctr+i}, registered, so it is visible in cycle T+1.
  - in_data enters a delay line of AES_LATENCY+1 stages, together with a valid bit.
  - ctr advances by LANES.
- Counter arithmetic: ctr+i is modulo 2^64 and iv never changes, so lane counters 0xFFFF_FFFF_FFFF_FFFF and 0x0 can appear in the same beat.
- At T+1+AES_LATENCY the delayed plaintext is XORed with aes_ks_in and written to the FIFO.
- out_valid is first asserted at T+AES_LATENCY+2 when the FIFO was empty; end-to-end latency is AES_LATENCY+2.
- Credit accounting:
  - inflight increments on issue and decrements on FIFO write; it is updated in the same cycle for simultaneous events.
  - The FIFO can therefore never overflow; a write to a full FIFO is an assertion error.
- FIFO ordering: FIFO order equals input order. A simultaneous read and write when full or empty is legal (read-before-write semantics); out_data holds stable while out_valid && !out_ready.
- Reset mid-job clears everything, including in-flight delay-line beats, and produces no done pulse.
- busy = state != IDLE.

Test Plan:
- Single beat: LANES=4, iv=0x0123456789ABCDEF, ctr_init=0, num_beats=1.
  - aes_state_out lanes = {iv,0},{iv,1},{iv,2},{iv,3}.
  - Bench AES model returns ks; out_data = pt^ks at cycle T+23.
  - done pulses once; busy drops the cycle after.
- Streaming 64 beats with out_ready=1 continuously: in_ready stays high and the output carries 64 ordered beats. The last lane counter is 255 and the done pulse comes after beat 64.
- Backpressure: out_ready=0 for 200 cycles with 100 beats requested.
  - Exactly 32 beats are accepted, then in_ready=0.
  - Releasing out_ready yields all 100 beats in order with no loss or duplication.
- Wrap: ctr_init=0xFFFF_FFFF_FFFF_FFFE, num_beats=1 gives lane counters FFFE, FFFF, 0, 1, with iv unchanged.
- Edge controls:
  - num_beats=0 gives done one cycle after start and aes_valid_out never asserts.
  - A start pulse during RUN is ignored; the current job's counters are unchanged.
- Asynchronous reset asserted at beat 10 of 40: all outputs go to 0 immediately with no done pulse; a new job after reset runs cleanly from ctr_init.
